forward_unit: RTL

//  Producer of the 3-bit bypass_ex code consumed by the EX-stage ALU operand mux, plus load-use stall control.

---
 rtl/fwd_pkg.sv | 30 +++
 rtl/forward_unit_hazard_cmp.sv | 22 ++
 rtl/forward_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the ID-stage forwarding / load-use stall unit.
package fwd_pkg;

  // Register-number width carried in the shadow tags.
  localparam int FWD_AW = 5;

  // ALU operand-source selector decoded in ID.
  localparam logic [1:0] ALU_R    = 2'b00;
  localparam logic [1:0] ALU_I    = 2'b01;
  localparam logic [1:0] ALU_SH   = 2'b11;
  localparam logic [1:0] ALU_NONE = 2'b10;

  // Bypass codes for the EX operand mux: bit1 = op1 path, bit0 = op2 path,
  // bit2 = source is WB (set) or EX/MEM (clear).
  localparam logic [2:0] BP_NONE  = 3'b000;
  localparam logic [2:0] BP_A_MEM = 3'b010;
  localparam logic [2:0] BP_A_WB  = 3'b110;
  localparam logic [2:0] BP_B_MEM = 3'b001;
  localparam logic [2:0] BP_B_WB  = 3'b101;

  // Destination tag of an in-flight instruction.
  typedef struct packed {
    logic [FWD_AW-1:0] dst;
    logic              we;
    logic              load;
  } fwd_tag_t;

  localparam fwd_tag_t TAG_EMPTY = '{dst: '0, we: 1'b0, load: 1'b0};

endpackage

// File: rtl/forward_unit_hazard_cmp.sv
// Compares one decoding source register against the EX-entry (E) and
// MEM-entry (M) shadow tags. Register 0 never matches.
module hazard_cmp
  import fwd_pkg::*;
(
  input  logic [FWD_AW-1:0] src,
  input  logic              used,
  input  fwd_tag_t          e,
  input  fwd_tag_t          m,
  output logic              hit_e,
  output logic              hit_m,
  output logic              hit_load
);

  logic src_live;

  assign src_live = used && (src != {FWD_AW{1'b0}});
  assign hit_e    = src_live && e.we && (e.dst == src);
  assign hit_m    = src_live && m.we && (m.dst == src);
  assign hit_load = hit_e && e.load;

endmodule

// File: rtl/forward_unit.sv
// ID-stage forwarding unit: produces the registered bypass code for the EX
// operand mux and the combinational load-use / dual-forward stall.
module forward_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW = FWD_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_en,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [1:0]        id_alu_src,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_we,
  input  logic              id_mem_read,
  output logic [2:0]        bypass_ex,
  output logic              stall_id,
  output logic [CNT_W-1:0]  stall_cnt
);

  fwd_tag_t e_tag;
  fwd_tag_t m_tag;

  logic use_rs;
  logic use_rt;
  logic rs_hit_e, rs_hit_m, rs_hit_load;
  logic rt_hit_e, rt_hit_m, rt_hit_load;
  logic load_use;
  logic dual;
  logic [2:0] code;
  logic bubble;

  // Shift instructions read rt only; it travels on the op1 path but keeps
  // the op2 code so the EX mux knows which register file port it replaces.
  assign use_rs = (id_alu_src == ALU_R) || (id_alu_src == ALU_I);
  assign use_rt = (id_alu_src == ALU_R) || (id_alu_src == ALU_SH);

  hazard_cmp u_rs_cmp (
    .src      (id_rs),
    .used     (use_rs),
    .e        (e_tag),
    .m        (m_tag),
    .hit_e    (rs_hit_e),
    .hit_m    (rs_hit_m),
    .hit_load (rs_hit_load)
  );

  hazard_cmp u_rt_cmp (
    .src      (id_rt),
    .used     (use_rt),
    .e        (e_tag),
    .m        (m_tag),
    .hit_e    (rt_hit_e),
    .hit_m    (rt_hit_m),
    .hit_load (rt_hit_load)
  );

  // Hazard detection and bypass-code selection (E wins over M per operand).
  always_comb begin
    load_use = rs_hit_load || rt_hit_load;
    dual     = (id_alu_src == ALU_R) &&
               (rs_hit_e || rs_hit_m) && (rt_hit_e || rt_hit_m);
    if (id_valid && !flush) begin
      stall_id = load_use || dual;
    end else begin
      stall_id = 1'b0;
    end
    if (rs_hit_e) begin
      code = BP_A_MEM;
    end else if (rs_hit_m) begin
      code = BP_A_WB;
    end else if (rt_hit_e) begin
      code = BP_B_MEM;
    end else if (rt_hit_m) begin
      code = BP_B_WB;
    end else begin
      code = BP_NONE;
    end
    bubble = stall_id || flush || !id_valid;
  end

  // Shadow tags and the registered bypass code advance with the pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_tag     <= TAG_EMPTY;
      m_tag     <= TAG_EMPTY;
      bypass_ex <= BP_NONE;
    end else if (pipe_en) begin
      m_tag <= e_tag;
      if (bubble) begin
        e_tag     <= TAG_EMPTY;
        bypass_ex <= BP_NONE;
      end else begin
        e_tag     <= '{dst: id_dst, we: id_we, load: id_mem_read};
        bypass_ex <= code;
      end
    end
  end

  // Saturating count of cycles the pipeline actually spent stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (pipe_en && stall_id && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
